// File: rtl/ber_checker.sv
// rtl/ber_checker.sv - slicer-vs-PRBS bit error rate checker with exhaustive delay search
//
// Ports: clk, i_reset (sync active-high), i_en_rx / i_en_rate1 (symbol strobe gates),
//        i_resync (restart search), i_ref_bit (transmitted PRBS bit), i_rx_sym (slicer symbol),
//        o_locked, o_delay, o_bit_cnt, o_err_cnt.
module ber_checker #(
    parameter int NBT_IN   = 12,
    parameter int DLY_LEN  = 512,
    parameter int NB_DLY   = 9,
    parameter int SYNC_LEN = 511,
    parameter int NB_SYNC  = 9,
    parameter int NB_CNT   = 64
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_en_rx,
    input  logic              i_en_rate1,
    input  logic              i_resync,
    input  logic              i_ref_bit,
    input  logic [NBT_IN-1:0] i_rx_sym,
    output logic              o_locked,
    output logic [NB_DLY-1:0] o_delay,
    output logic [NB_CNT-1:0] o_bit_cnt,
    output logic [NB_CNT-1:0] o_err_cnt
);

    typedef enum logic [0:0] {SEARCH, LOCKED} state_t;

    state_t              state_q, state_d;
    logic [NB_DLY-1:0]   cand_q, cand_d;
    logic [NB_DLY-1:0]   best_q, best_d;
    logic [NB_DLY-1:0]   delay_q, delay_d;
    logic [NB_SYNC-1:0]  win_cnt_q, win_cnt_d;
    logic [NB_SYNC-1:0]  err_acc_q, err_acc_d;
    logic [NB_SYNC-1:0]  min_err_q, min_err_d;
    logic [DLY_LEN-1:0]  ref_sr_q, ref_sr_d;
    logic [NB_CNT-1:0]   bit_cnt_q, bit_cnt_d;
    logic [NB_CNT-1:0]   err_cnt_q, err_cnt_d;

    logic                stb;
    logic                rx_bit;
    logic                mism;
    logic [NB_DLY-1:0]   idx;
    logic [NB_SYNC-1:0]  win_sum;
    logic [NB_DLY-1:0]   best_next;
    logic [NBT_IN-2:0]   unused_sym_lsbs;

    assign stb             = i_en_rx & i_en_rate1;
    // Only the sign of the slicer decision carries the bit: +1 -> 0, -1 -> 1.
    assign rx_bit          = i_rx_sym[NBT_IN-1];
    assign unused_sym_lsbs = i_rx_sym[NBT_IN-2:0];

    // Pre-shift tap: index d selects the reference bit from d+1 strobes ago.
    assign idx     = (state_q == LOCKED) ? delay_q : cand_q;
    assign mism    = rx_bit ^ ref_sr_q[idx];
    assign win_sum = err_acc_q + {{(NB_SYNC-1){1'b0}}, mism};
    // Strict compare keeps the earliest (lowest) delay on ties.
    assign best_next = (win_sum < min_err_q) ? cand_q : best_q;

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        best_d    = best_q;
        delay_d   = delay_q;
        win_cnt_d = win_cnt_q;
        err_acc_d = err_acc_q;
        min_err_d = min_err_q;
        ref_sr_d  = ref_sr_q;
        bit_cnt_d = bit_cnt_q;
        err_cnt_d = err_cnt_q;

        if (i_resync) begin
            // Reference history survives a resync; everything else restarts.
            state_d   = SEARCH;
            cand_d    = '0;
            best_d    = '0;
            delay_d   = '0;
            win_cnt_d = '0;
            err_acc_d = '0;
            min_err_d = '1;
            bit_cnt_d = '0;
            err_cnt_d = '0;
        end else if (stb) begin
            ref_sr_d = {ref_sr_q[DLY_LEN-2:0], i_ref_bit};
            case (state_q)
                SEARCH: begin
                    if (win_cnt_q < NB_SYNC'(SYNC_LEN - 1)) begin
                        win_cnt_d = win_cnt_q + NB_SYNC'(1);
                        err_acc_d = win_sum;
                    end else begin
                        if (win_sum < min_err_q) begin
                            min_err_d = win_sum;
                            best_d    = cand_q;
                        end
                        win_cnt_d = '0;
                        err_acc_d = '0;
                        if (cand_q == NB_DLY'(DLY_LEN - 1)) begin
                            state_d   = LOCKED;
                            delay_d   = best_next;
                            bit_cnt_d = '0;
                            err_cnt_d = '0;
                            cand_d    = '0;
                        end else begin
                            cand_d = cand_q + NB_DLY'(1);
                        end
                    end
                end
                LOCKED: begin
                    if (bit_cnt_q != '1) begin
                        bit_cnt_d = bit_cnt_q + NB_CNT'(1);
                    end
                    if (mism && (err_cnt_q != '1)) begin
                        err_cnt_d = err_cnt_q + NB_CNT'(1);
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q   <= SEARCH;
            cand_q    <= '0;
            best_q    <= '0;
            delay_q   <= '0;
            win_cnt_q <= '0;
            err_acc_q <= '0;
            min_err_q <= '1;
            ref_sr_q  <= '0;
            bit_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            best_q    <= best_d;
            delay_q   <= delay_d;
            win_cnt_q <= win_cnt_d;
            err_acc_q <= err_acc_d;
            min_err_q <= min_err_d;
            ref_sr_q  <= ref_sr_d;
            bit_cnt_q <= bit_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_locked  = (state_q == LOCKED);
    assign o_delay   = delay_q;
    assign o_bit_cnt = bit_cnt_q;
    assign o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_ber_checker.sv
// tb/tb_ber_checker.sv - self-checking bench for ber_checker
module tb_ber_checker;

    localparam int NBT = 12;
    localparam int DL  = 16;
    localparam int NBD = 4;
    localparam int SL  = 32;
    localparam int NBS = 6;
    localparam int NBC = 8;
    localparam int NSEARCH = DL * SL;
    localparam longint CMAX = (64'd1 << NBC) - 1;

    logic           clk = 1'b0;
    logic           i_reset = 1'b0;
    logic           i_en_rx = 1'b0;
    logic           i_en_rate1 = 1'b0;
    logic           i_resync = 1'b0;
    logic           i_ref_bit = 1'b0;
    logic [NBT-1:0] i_rx_sym = '0;
    logic           o_locked;
    logic [NBD-1:0] o_delay;
    logic [NBC-1:0] o_bit_cnt;
    logic [NBC-1:0] o_err_cnt;

    ber_checker #(
        .NBT_IN(NBT), .DLY_LEN(DL), .NB_DLY(NBD),
        .SYNC_LEN(SL), .NB_SYNC(NBS), .NB_CNT(NBC)
    ) dut (
        .clk(clk), .i_reset(i_reset), .i_en_rx(i_en_rx), .i_en_rate1(i_en_rate1),
        .i_resync(i_resync), .i_ref_bit(i_ref_bit), .i_rx_sym(i_rx_sym),
        .o_locked(o_locked), .o_delay(o_delay), .o_bit_cnt(o_bit_cnt), .o_err_cnt(o_err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endfunction

    // Reference model: whole-history arrays, windows scored at lock time.
    bit     ref_q[$];
    bit     rx_q[$];
    int     s0, scnt;
    bit     m_locked;
    int     m_delay;
    longint m_bit, m_err;

    function automatic int refat(input int i);
        return (i < 0) ? 0 : int'(ref_q[i]);
    endfunction

    function automatic int search_best();
        int minv = (1 << NBS) - 1;
        int best = 0;
        for (int d = 0; d < DL; d++) begin
            int sum = 0;
            for (int j = 0; j < SL; j++) begin
                int k = s0 + d * SL + j;
                sum += int'(rx_q[k]) ^ refat(k - 1 - d);
            end
            if (sum < minv) begin
                minv = sum;
                best = d;
            end
        end
        return best;
    endfunction

    function automatic void model_clear_out();
        m_locked = 0; m_delay = 0; m_bit = 0; m_err = 0; scnt = 0;
    endfunction

    function automatic void model_update(input bit rst, input bit en, input bit rate,
                                         input bit rs, input bit rbit, input bit xbit);
        if (rst) begin
            ref_q.delete(); rx_q.delete(); s0 = 0; model_clear_out();
        end else if (rs) begin
            s0 = ref_q.size(); model_clear_out();
        end else if (en && rate) begin
            int k = ref_q.size();
            if (m_locked) begin
                if (m_bit < CMAX) m_bit++;
                if ((xbit ^ bit'(refat(k - 1 - m_delay))) && m_err < CMAX) m_err++;
            end
            ref_q.push_back(rbit);
            rx_q.push_back(xbit);
            if (!m_locked) begin
                scnt++;
                if (scnt == NSEARCH) begin
                    m_delay = search_best();
                    m_locked = 1; m_bit = 0; m_err = 0;
                end
            end
        end
    endfunction

    task automatic step(input bit rst, input bit en, input bit rate, input bit rs,
                        input bit rbit, input bit xbit);
        logic [NBT-2:0] lsbs;
        lsbs = NBT'($urandom);
        i_reset = rst; i_en_rx = en; i_en_rate1 = rate; i_resync = rs;
        i_ref_bit = rbit; i_rx_sym = {xbit, lsbs};
        @(posedge clk);
        model_update(rst, en, rate, rs, rbit, xbit);
        #1;
        chk("model_locked", o_locked, m_locked);
        chk("model_delay", o_delay, m_delay);
        chk("model_bit_cnt", o_bit_cnt, m_bit);
        chk("model_err_cnt", o_err_cnt, m_err);
        @(negedge clk);
    endtask

    // Stimulus: PRBS9 (x^9+x^5+1) reference, rx derived from it.
    logic [8:0] lfsr;
    bit         hist[$];
    int         ph;

    task automatic stim_reset();
        lfsr = 9'h1FF; hist.delete(); ph = 0;
        step(1, 0, 0, 0, 0, 0);
    endtask

    // stbmode: 0 = strobe every 2nd cycle, 1 = random, 2 = en_rx held low.
    // rxmode: 0 = ref delayed 5 strobes, 1 = constant +1, 2 = delayed with random errors.
    task automatic run(input int ncyc, input int rxmode, input int inv, input int stbmode,
                       input bit stop_on_lock, output int used);
        int sc = 0;
        used = 0;
        for (int c = 0; c < ncyc; c++) begin
            bit en, rate, stb, del, xbit, rbit;
            en   = (stbmode == 0) ? 1'b1 : (stbmode == 1) ? ($urandom % 4 != 0) : 1'b0;
            rate = (stbmode == 1) ? bit'($urandom % 2) : bit'(ph % 2);
            ph++;
            stb  = en & rate;
            rbit = lfsr[8];
            del  = (hist.size() >= 5) ? hist[hist.size() - 5] : 1'b0;
            xbit = (rxmode == 1) ? 1'b0 : (rxmode == 2) ? (del ^ ($urandom % 8 == 0)) : del;
            if (stb) begin
                sc++;
                if (inv != 0 && sc % inv == 0) xbit = ~xbit;
            end
            step(0, en, rate, 0, rbit, xbit);
            used++;
            if (stb) begin
                hist.push_back(rbit);
                lfsr = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
            end
            if (stop_on_lock && o_locked) break;
        end
    endtask

    typedef struct {
        bit rst, en, rate, rs, rbit, xbit;
        bit exp_locked; int exp_delay; int exp_bit; int exp_err;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int   used, c1, c2;

        vecs[0] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1] = '{0, 1, 1, 0, 1, 1, 0, 0, 0, 0};
        vecs[2] = '{0, 0, 1, 0, 1, 0, 0, 0, 0, 0};
        vecs[3] = '{0, 1, 1, 1, 0, 1, 0, 0, 0, 0};
        vecs[4] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        vecs[5] = '{0, 1, 0, 0, 1, 1, 0, 0, 0, 0};

        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].rate, vecs[i].rs, vecs[i].rbit, vecs[i].xbit);
            chk("vec_locked", o_locked, vecs[i].exp_locked);
            chk("vec_delay", o_delay, vecs[i].exp_delay);
            chk("vec_bit_cnt", o_bit_cnt, vecs[i].exp_bit);
            chk("vec_err_cnt", o_err_cnt, vecs[i].exp_err);
        end

        // Aligned PRBS, exact lock timing and delay.
        stim_reset();
        run(2 * NSEARCH + 100, 0, 0, 0, 1, c1);
        chk("lock_reached", o_locked, 1);
        chk("lock_cycles", c1, 2 * NSEARCH);
        chk("lock_delay", o_delay, 4);
        chk("lock_bit_cnt_zero", o_bit_cnt, 0);

        // Error injection on every 10th locked symbol.
        run(200, 0, 10, 0, 0, used);
        chk("inj_bit_cnt", o_bit_cnt, 100);
        chk("inj_err_cnt", o_err_cnt, 10);

        // Resync with a strobe in the same cycle.
        step(0, 1, 1, 1, lfsr[8], 1'b1);
        ph++;
        chk("resync_locked", o_locked, 0);
        chk("resync_delay", o_delay, 0);
        chk("resync_bit_cnt", o_bit_cnt, 0);
        chk("resync_err_cnt", o_err_cnt, 0);
        run(2 * NSEARCH + 100, 0, 0, 0, 1, used);
        chk("relock_reached", o_locked, 1);
        chk("relock_delay", o_delay, 4);

        // Enable stall mid-search delays lock by exactly the stall length.
        stim_reset();
        run(300, 0, 0, 0, 0, used);
        c2 = used;
        run(50, 0, 0, 2, 0, used);
        c2 += used;
        run(2 * NSEARCH, 0, 0, 0, 1, used);
        c2 += used;
        chk("stall_locked", o_locked, 1);
        chk("stall_cycles", c2, c1 + 50);
        chk("stall_delay", o_delay, 4);

        // Saturation with every locked symbol inverted, then reset.
        run(600, 0, 1, 0, 0, used);
        chk("sat_bit_cnt", o_bit_cnt, CMAX);
        chk("sat_err_cnt", o_err_cnt, CMAX);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_locked", o_locked, 0);
        chk("rst_delay", o_delay, 0);
        chk("rst_bit_cnt", o_bit_cnt, 0);
        chk("rst_err_cnt", o_err_cnt, 0);

        // Random strobes and noisy rx, with a resync in the middle of a search.
        stim_reset();
        run(400, 2, 0, 1, 0, used);
        step(0, 1, 1, 1, lfsr[8], 1'b0);
        run(6000, 2, 0, 1, 1, used);
        chk("rand_locked", o_locked, 1);
        run(800, 2, 0, 1, 0, used);

        // Constant +1 rx: lock delay chosen by the model's tie rules.
        stim_reset();
        run(2 * NSEARCH + 100, 1, 0, 0, 1, used);
        chk("const_locked", o_locked, 1);
        run(400, 1, 0, 0, 0, used);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
